// File: rtl/writeback_pkg.sv
// Shared Y86-64 definitions: status codes, special register IDs and
// the status normalisation helper.
package y86_pkg;

   typedef enum logic [2:0] {
      STAT_AOK = 3'd1,
      STAT_HLT = 3'd2,
      STAT_ADR = 3'd3,
      STAT_INS = 3'd4
   } stat_t;

   localparam logic [3:0] REG_RSP  = 4'd4;
   localparam logic [3:0] REG_NONE = 4'hF;

   // Undefined encodings are treated as an invalid instruction.
   function automatic stat_t norm_stat(input logic [2:0] s);
      case (s)
         3'd1:    return STAT_AOK;
         3'd2:    return STAT_HLT;
         3'd3:    return STAT_ADR;
         default: return STAT_INS;
      endcase
   endfunction

endpackage

// File: rtl/writeback_reg_file.sv
// Y86-64 architectural register file: 15 x 64-bit, two write ports
// (M wins over E on collision) and three combinational read ports.
module reg_file
   import y86_pkg::*;
#(
   parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [3:0]  dst_e,
   input  logic [63:0] val_e,
   input  logic [3:0]  dst_m,
   input  logic [63:0] val_m,
   input  logic [3:0]  src_a,
   input  logic [3:0]  src_b,
   input  logic [3:0]  src_c,
   output logic [63:0] rval_a,
   output logic [63:0] rval_b,
   output logic [63:0] rval_c
);

   logic [63:0] regs [0:14];

   // The M write is issued last so it overrides E when both target one ID.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < 15; i++) begin
            regs[i] <= (i == 32'(REG_RSP)) ? STACK_INIT : '0;
         end
      end else if (we) begin
         if (dst_e != REG_NONE) regs[dst_e] <= val_e;
         if (dst_m != REG_NONE) regs[dst_m] <= val_m;
      end
   end

   assign rval_a = (src_a == REG_NONE) ? '0 : regs[src_a];
   assign rval_b = (src_b == REG_NONE) ? '0 : regs[src_b];
   assign rval_c = (src_c == REG_NONE) ? '0 : regs[src_c];

endmodule

// File: rtl/writeback.sv
// SEQ Y86-64 write-back stage: sticky status latch, commit gating,
// retired-instruction counter and the architectural register file.
module writeback
   import y86_pkg::*;
#(
   parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  stat_in,
   input  logic [3:0]  dstE,
   input  logic [63:0] valE,
   input  logic [3:0]  dstM,
   input  logic [63:0] valM,
   input  logic [3:0]  srcA,
   input  logic [3:0]  srcB,
   output logic [63:0] rvalA,
   output logic [63:0] rvalB,
   input  logic [3:0]  dbg_reg,
   output logic [63:0] dbg_val,
   output logic [2:0]  stat,
   output logic        halted,
   output logic [63:0] retired
);

   stat_t stat_q;
   stat_t stat_in_n;
   logic  commit;

   assign stat_in_n = norm_stat(stat_in);
   assign commit    = (stat_q == STAT_AOK) && (stat_in_n == STAT_AOK);

   // Once non-AOK the status is sticky until reset; the faulting
   // instruction itself neither writes nor counts.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_q  <= STAT_AOK;
         retired <= '0;
      end else if (stat_q == STAT_AOK) begin
         if (stat_in_n != STAT_AOK) stat_q  <= stat_in_n;
         else                       retired <= retired + 64'd1;
      end
   end

   assign stat   = stat_q;
   assign halted = (stat_q != STAT_AOK);

   reg_file #(
      .STACK_INIT(STACK_INIT)
   ) u_reg_file (
      .clk    (clk),
      .reset  (reset),
      .we     (commit),
      .dst_e  (dstE),
      .val_e  (valE),
      .dst_m  (dstM),
      .val_m  (valM),
      .src_a  (srcA),
      .src_b  (srcB),
      .src_c  (dbg_reg),
      .rval_a (rvalA),
      .rval_b (rvalB),
      .rval_c (dbg_val)
   );

endmodule

// File: tb/tb_writeback.sv
// Directed plus randomized bench for writeback against a behavioural
// model of the register file, status latch and retired counter.
module tb_writeback;

   localparam logic [63:0] STACK_INIT = 64'h0000_0000_0000_1000;

   logic        clk;
   logic        reset;
   logic [2:0]  stat_in;
   logic [3:0]  dstE;
   logic [63:0] valE;
   logic [3:0]  dstM;
   logic [63:0] valM;
   logic [3:0]  srcA;
   logic [3:0]  srcB;
   logic [63:0] rvalA;
   logic [63:0] rvalB;
   logic [3:0]  dbg_reg;
   logic [63:0] dbg_val;
   logic [2:0]  stat;
   logic        halted;
   logic [63:0] retired;

   writeback #(.STACK_INIT(STACK_INIT)) dut (
      .clk     (clk),
      .reset   (reset),
      .stat_in (stat_in),
      .dstE    (dstE),
      .valE    (valE),
      .dstM    (dstM),
      .valM    (valM),
      .srcA    (srcA),
      .srcB    (srcB),
      .rvalA   (rvalA),
      .rvalB   (rvalB),
      .dbg_reg (dbg_reg),
      .dbg_val (dbg_val),
      .stat    (stat),
      .halted  (halted),
      .retired (retired)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // Reference state; index 15 stands for RNONE and always reads 0.
   logic [63:0] m_r [0:15];
   int unsigned m_stat;
   logic [63:0] m_ret;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_r[i] = '0;
      m_r[4] = STACK_INIT;
      m_stat = 1;
      m_ret  = '0;
   endtask

   task automatic model_edge(input logic rst, input logic [2:0] s,
                             input logic [3:0] de, input logic [63:0] ve,
                             input logic [3:0] dm, input logic [63:0] vm);
      int unsigned n;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_stat != 1) return;
      n = (s >= 1 && s <= 4) ? int'(s) : 4;
      if (n != 1) begin
         m_stat = n;
         return;
      end
      if (de != 4'hF) m_r[de] = ve;
      if (dm != 4'hF) m_r[dm] = vm;
      m_ret = m_ret + 1;
   endtask

   // Called shortly after a rising edge; all probes finish well before the next one.
   task automatic check_state(input string tag);
      logic [3:0] a, b, c;
      for (int k = 0; k < 6; k++) begin
         a = 4'(3 * k);
         b = 4'(3 * k + 1);
         c = 4'(3 * k + 2);
         srcA = a; srcB = b; dbg_reg = c;
         #1;
         chk({tag, ".rvalA"}, rvalA, m_r[a]);
         chk({tag, ".rvalB"}, rvalB, m_r[b]);
         chk({tag, ".dbg"},   dbg_val, m_r[c]);
      end
      chk({tag, ".stat"},    64'(stat),    64'(m_stat));
      chk({tag, ".halted"},  64'(halted),  64'(m_stat != 1));
      chk({tag, ".retired"}, retired,      m_ret);
   endtask

   task automatic step(input string tag, input logic rst, input logic [2:0] s,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
      reset = rst; stat_in = s; dstE = de; valE = ve; dstM = dm; valM = vm;
      srcA = de; srcB = dm;
      #1;
      // Same-cycle reads of the destinations still see the pre-edge contents.
      chk({tag, ".pre_a"}, rvalA, m_r[de]);
      chk({tag, ".pre_b"}, rvalB, m_r[dm]);
      @(posedge clk);
      model_edge(rst, s, de, ve, dm, vm);
      #1;
      check_state(tag);
      reset = 1'b0;
   endtask

   initial begin
      logic        r_rst;
      logic [2:0]  r_s;
      logic [3:0]  r_de, r_dm;
      logic [63:0] r_ve, r_vm;

      reset = 1'b1; stat_in = 3'd1; dstE = 4'hF; valE = '0; dstM = 4'hF; valM = '0;
      srcA = 4'd0; srcB = 4'd0; dbg_reg = 4'd0;
      model_reset();
      #1;

      step("reset",    1'b1, 3'd1, 4'hF, 64'h0,      4'hF, 64'h0);
      step("dual",     1'b0, 3'd1, 4'd0, 64'h1234,   4'd3, 64'h5678);
      step("collide",  1'b0, 3'd1, 4'd4, 64'hFF8,    4'd4, 64'hABCD);
      step("fault",    1'b0, 3'd3, 4'hF, 64'h0,      4'd2, 64'hDEAD);
      step("sticky",   1'b0, 3'd1, 4'd1, 64'h7777,   4'hF, 64'h0);
      step("rst2",     1'b1, 3'd1, 4'hF, 64'h0,      4'hF, 64'h0);
      step("norm0",    1'b0, 3'd0, 4'd6, 64'h1,      4'd7, 64'h2);
      step("rst3",     1'b1, 3'd1, 4'hF, 64'h0,      4'hF, 64'h0);
      step("rnone",    1'b0, 3'd1, 4'hF, 64'hAAAA,   4'hF, 64'hBBBB);
      step("norm7",    1'b0, 3'd7, 4'd5, 64'h3,      4'hF, 64'h0);
      step("rst4",     1'b1, 3'd1, 4'hF, 64'h0,      4'hF, 64'h0);
      step("hlt",      1'b0, 3'd2, 4'd5, 64'h9,      4'hF, 64'h0);
      step("rst_halt", 1'b1, 3'd1, 4'hF, 64'h0,      4'hF, 64'h0);
      step("r5",       1'b0, 3'd1, 4'd5, 64'hC0FFEE, 4'hF, 64'h0);
      step("rst_wr",   1'b1, 3'd1, 4'd6, 64'h55,     4'd7, 64'h66);

      for (int t = 0; t < 300; t++) begin
         r_rst = ($urandom_range(0, 39) == 0);
         r_s   = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
         r_de  = 4'($urandom_range(0, 15));
         r_dm  = ($urandom_range(0, 5) == 0) ? r_de : 4'($urandom_range(0, 15));
         r_ve  = {$urandom, $urandom};
         r_vm  = {$urandom, $urandom};
         step("rand", r_rst, r_s, r_de, r_ve, r_dm, r_vm);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
